// File: rtl/diff_wb_queue.sv
// diff_wb_queue: FIFO buffering diff bit-index results between the diff unit
// and register writeback, with a no-diff counter and a sticky range flag.
//
// Ports:
//   clk, rst           single clock; asynchronous active-low reset
//   flush              synchronous discard of all queued entries
//   in_valid/in_ready  producer handshake; in_result (0..32), in_rd
//   out_valid/out_ready writeback handshake; out_result, out_rd from the head
//   out_wren           head present and destination is not register 0
//   out_nodiff         head present and result is 32 (no differing bit)
//   count              current occupancy
//   nodiff_cnt         saturating count of accepted pushes with result 32
//   err_range          sticky: an accepted push carried a result above 32
module diff_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RDW   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic [RDW-1:0]           in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [RDW-1:0]           out_rd,
  output logic                     out_wren,
  output logic                     out_nodiff,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              nodiff_cnt,
  output logic                     err_range
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] NODIFF_VAL = 32'd32;

  logic [31:0]    r_mem_res [DEPTH];
  logic [RDW-1:0] r_mem_rd  [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [15:0]    r_nodiff_cnt;
  logic           r_err_range;

  logic           w_in_ready;
  logic           w_out_valid;
  logic           w_push;
  logic           w_pop;

  // Handshake status comes only from registered occupancy, so there is no
  // combinational path from out_ready to in_ready.
  assign w_in_ready  = (r_count != CW'(DEPTH));
  assign w_out_valid = (r_count != CW'(0));

  // Flush wins over any same-cycle transfer; a flushed push is not accepted.
  assign w_push = in_valid  && w_in_ready  && !flush;
  assign w_pop  = out_valid && out_ready   && !flush;

  // Entry storage, written at the tail on each accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_res[i] <= '0;
        r_mem_rd[i]  <= '0;
      end
    end else if (w_push) begin
      r_mem_res[r_wptr] <= in_result;
      r_mem_rd[r_wptr]  <= in_rd;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nodiff_cnt <= '0;
      r_err_range  <= 1'b0;
    end else if (w_push) begin
      if ((in_result == NODIFF_VAL) && (r_nodiff_cnt != 16'hFFFF)) begin
        r_nodiff_cnt <= r_nodiff_cnt + 16'd1;
      end
      if (in_result > NODIFF_VAL) begin
        r_err_range <= 1'b1;
      end
    end
  end

  // Head is presented straight from storage with no extra register stage.
  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign out_result = r_mem_res[r_rptr];
  assign out_rd     = r_mem_rd[r_rptr];
  assign out_wren   = w_out_valid && (r_mem_rd[r_rptr] != RDW'(0));
  assign out_nodiff = w_out_valid && (r_mem_res[r_rptr] == NODIFF_VAL);
  assign count      = r_count;
  assign nodiff_cnt = r_nodiff_cnt;
  assign err_range  = r_err_range;

endmodule

// File: tb/tb_diff_wb_queue.sv
// Self-checking bench for diff_wb_queue: a queue of expected entries is
// filled as pushes are driven and drained as the DUT presents its head.
module tb_diff_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RDW   = 5;
  localparam int unsigned CW    = 3;

  typedef struct packed {
    logic [31:0]    res;
    logic [RDW-1:0] rd;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [31:0]    in_result = '0;
  logic [RDW-1:0] in_rd = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [31:0]    out_result;
  logic [RDW-1:0] out_rd;
  logic           out_wren;
  logic           out_nodiff;
  logic [CW-1:0]  count;
  logic [15:0]    nodiff_cnt;
  logic           err_range;

  ent_t exp_q[$];
  int   m_cnt = 0;
  int   m_nd  = 0;
  logic m_err = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  diff_wb_queue #(.DEPTH(DEPTH), .RDW(RDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wren   (out_wren),
    .out_nodiff (out_nodiff),
    .count      (count),
    .nodiff_cnt (nodiff_cnt),
    .err_range  (err_range)
  );

  always #5 clk = ~clk;

  // Drive one cycle from a falling edge and advance the reference model.
  task automatic step(input logic v, input logic [31:0] res, input logic [RDW-1:0] rd,
                      input logic ordy, input logic fl);
    logic push;
    logic pop;
    ent_t e;
    in_valid  = v;
    in_result = res;
    in_rd     = rd;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    push = v && (m_cnt != int'(DEPTH)) && !fl;
    pop  = ordy && (m_cnt != 0) && !fl;
    if (fl) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        m_cnt--;
      end
      if (push) begin
        e.res = res;
        e.rd  = rd;
        exp_q.push_back(e);
        m_cnt++;
        if (res == 32'd32 && m_nd != 65535) m_nd++;
        if (res > 32'd32) m_err = 1'b1;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: count=%0d in_ready=%b out_valid=%b required 0/1/0", count, in_ready, out_valid);
    end
    vectors++;
    if (out_wren !== 1'b0 || out_nodiff !== 1'b0 || nodiff_cnt !== 16'd0 || err_range !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: wren=%b nodiff=%b nd_cnt=%0d err=%b required all 0", out_wren, out_nodiff, nodiff_cnt, err_range);
    end
    vectors++;
    if (out_result !== 32'd0 || out_rd !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_head: result=%0d rd=%0d required 0/0", out_result, out_rd);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);  // pop on empty has no effect
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_pop: count=%0d out_valid=%b required 0/0", count, out_valid);
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0]    vals [4] = '{32'd5, 32'd32, 32'd0, 32'd17};
    logic [RDW-1:0] rds  [4] = '{5'd1, 5'd2, 5'd0, 5'd3};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], rds[i], 1'b0, 1'b0);
      if (i == 0) begin
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'd5) begin
          miscompares++;
          $display("FAIL first_latency: valid=%b result=%0d required 1/5", out_valid, out_result);
        end
      end
    end
    vectors++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: count=%0d in_ready=%b required 4/0", count, in_ready);
    end
    step(1'b1, 32'd99, 5'd9, 1'b0, 1'b0);  // push into full is ignored
    vectors++;
    if (count !== 3'd4 || out_result !== 32'd5) begin
      miscompares++;
      $display("FAIL full_push_ignored: count=%0d head=%0d required 4/5", count, out_result);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_result !== exp_q[0].res || out_rd !== exp_q[0].rd) begin
        miscompares++;
        $display("FAIL drain_head[%0d]: valid=%b result=%0d rd=%0d required 1/%0d/%0d", i, out_valid, out_result, out_rd, exp_q[0].res, exp_q[0].rd);
      end
      vectors++;
      if (out_nodiff !== (exp_q[0].res == 32'd32) || out_wren !== (exp_q[0].rd != 5'd0)) begin
        miscompares++;
        $display("FAIL drain_flags[%0d]: nodiff=%b wren=%b required %b/%b", i, out_nodiff, out_wren, exp_q[0].res == 32'd32, exp_q[0].rd != 5'd0);
      end
      step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
    end
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || nodiff_cnt !== 16'(m_nd) || m_nd != 1) begin
      miscompares++;
      $display("FAIL drain_end: count=%0d valid=%b nd_cnt=%0d required 0/0/1", count, out_valid, nodiff_cnt);
    end
  endtask

  task automatic test_full_traffic();
    for (int i = 0; i < 4; i++) step(1'b1, 32'(100 + i), 5'(i + 4), 1'b0, 1'b0);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_in_ready: got %b required 0", in_ready);
    end
    step(1'b1, 32'd200, 5'd7, 1'b1, 1'b0);
    vectors++;
    if (count !== 3'd3 || in_ready !== 1'b1 || out_result !== 32'd101) begin
      miscompares++;
      $display("FAIL full_pop_only: count=%0d in_ready=%b head=%0d required 3/1/101", count, in_ready, out_result);
    end
    step(1'b1, 32'd201, 5'd8, 1'b0, 1'b0);
    vectors++;
    if (count !== 3'(m_cnt) || m_cnt != 4) begin
      miscompares++;
      $display("FAIL full_next_push: count=%0d required 4", count);
    end
    while (m_cnt != 0) begin
      vectors++;
      if (out_result !== exp_q[0].res || out_rd !== exp_q[0].rd) begin
        miscompares++;
        $display("FAIL full_drain: result=%0d rd=%0d required %0d/%0d", out_result, out_rd, exp_q[0].res, exp_q[0].rd);
      end
      step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'd1, 5'd1, 1'b0, 1'b0);
    step(1'b1, 32'd2, 5'd2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (out_result !== exp_q[0].res || out_rd !== exp_q[0].rd) begin
        miscompares++;
        $display("FAIL stream_head[%0d]: result=%0d rd=%0d required %0d/%0d", i, out_result, out_rd, exp_q[0].res, exp_q[0].rd);
      end
      step(1'b1, 32'($urandom_range(0, 32)), 5'(i + 10), 1'b1, 1'b0);
      vectors++;
      if (count !== 3'd2) begin
        miscompares++;
        $display("FAIL stream_count[%0d]: got %0d required 2", i, count);
      end
    end
    while (m_cnt != 0) begin
      vectors++;
      if (out_result !== exp_q[0].res || out_rd !== exp_q[0].rd) begin
        miscompares++;
        $display("FAIL stream_drain: result=%0d rd=%0d required %0d/%0d", out_result, out_rd, exp_q[0].res, exp_q[0].rd);
      end
      step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush();
    int nd_before;
    step(1'b1, 32'd32, 5'd1, 1'b0, 1'b0);
    step(1'b1, 32'd3, 5'd2, 1'b0, 1'b0);
    step(1'b1, 32'd4, 5'd3, 1'b0, 1'b0);
    nd_before = m_nd;
    vectors++;
    if (count !== 3'd3) begin
      miscompares++;
      $display("FAIL flush_pre: count=%0d required 3", count);
    end
    step(1'b1, 32'd32, 5'd4, 1'b1, 1'b1);
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || nodiff_cnt !== 16'(nd_before)) begin
      miscompares++;
      $display("FAIL flush: count=%0d valid=%b nd_cnt=%0d required 0/0/%0d", count, out_valid, nodiff_cnt, nd_before);
    end
    step(1'b1, 32'd8, 5'd5, 1'b0, 1'b0);  // pointers restart cleanly
    vectors++;
    if (out_valid !== 1'b1 || out_result !== 32'd8 || out_rd !== 5'd5) begin
      miscompares++;
      $display("FAIL post_flush_push: valid=%b result=%0d rd=%0d required 1/8/5", out_valid, out_result, out_rd);
    end
    step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic test_range();
    step(1'b1, 32'd40, 5'd9, 1'b0, 1'b0);
    vectors++;
    if (err_range !== m_err || m_err !== 1'b1 || out_result !== 32'd40 || out_nodiff !== 1'b0) begin
      miscompares++;
      $display("FAIL range_set: err=%b head=%0d nodiff=%b required 1/40/0", err_range, out_result, out_nodiff);
    end
    step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
    vectors++;
    if (err_range !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL range_after_flush: err=%b count=%0d required 1/0", err_range, count);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'd11, 5'd1, 1'b0, 1'b0);
    step(1'b1, 32'd12, 5'd2, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b count=%0d in_ready=%b required 0/0/1", out_valid, count, in_ready);
    end
    vectors++;
    if (err_range !== 1'b0 || nodiff_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL async_reset_stats: err=%b nd_cnt=%0d required 0/0", err_range, nodiff_cnt);
    end
    exp_q.delete();
    m_cnt = 0;
    m_nd  = 0;
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'd7, 5'd6, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_result !== 32'd7 || out_rd !== 5'd6 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL post_reset_push: valid=%b result=%0d rd=%0d count=%0d required 1/7/6/1", out_valid, out_result, out_rd, count);
    end
    step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_traffic();
    test_back_to_back();
    test_flush();
    test_range();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
